// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID pipeline register layout for the LEGv8 fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;
    localparam int unsigned        PC_INC   = 4;

    // IF/ID occupancy: the valid bit doubles as the EMPTY/FULL state
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter flop: synchronous reset, load override, then enable-gated update.
module pc_reg #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // A taken branch overrides a stall so the redirect is never lost
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: PC, ROM addressing and the IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned IW = 32,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_src,
    input  logic [N-1:0]  branch_target,
    input  logic          stall,
    input  logic          flush,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_q,
    output logic [N-1:0]  pc_if,
    output logic [N-1:0]  if_id_pc,
    output logic [IW-1:0] if_id_instr,
    output logic          if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   bubble_count
`endif
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] redirect_pc;
    logic         unused_bt_lsbs;

    assign pc_plus4       = pc_q + N'(PC_INC);
    assign redirect_pc    = {branch_target[N-1:2], 2'b00};
    assign unused_bt_lsbs = ^branch_target[1:0];

    pc_reg #(
        .W(N)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (~stall),
        .load    (pc_src),
        .load_val(redirect_pc),
        .d       (pc_plus4),
        .q       (pc_q)
    );

    assign pc_if     = pc_q;
    assign imem_addr = pc_q[AW+1:2];

    if_id_t if_id_q;
    if_id_t if_id_d;
    logic   if_id_load;

    assign if_id_load = ~flush & ~stall;

    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d.pc    = '0;
            if_id_d.instr = NOP_WORD;
            if_id_d.valid = ST_EMPTY;
        end else if (if_id_load) begin
            if_id_d.pc    = PC_W'(pc_q);
            if_id_d.instr = INSTR_W'(imem_q);
            if_id_d.valid = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q.pc    <= '0;
            if_id_q.instr <= NOP_WORD;
            if_id_q.valid <= ST_EMPTY;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_pc    = N'(if_id_q.pc);
    assign if_id_instr = IW'(if_id_q.instr);
    assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (if_id_load && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (flush && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a queue-based scoreboard.
module tb_fetch_stage;

    localparam int N  = 64;
    localparam int IW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pc_src = 1'b0;
    logic [N-1:0]  branch_target = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_q;
    logic [N-1:0]  pc_if;
    logic [N-1:0]  if_id_pc;
    logic [IW-1:0] if_id_instr;
    logic          if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count;
    logic [31:0]   bubble_count;
`endif

    fetch_stage #(.N(N), .IW(IW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .stall        (stall),
        .flush        (flush),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .pc_if        (pc_if),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [64];
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = 32'hf8000203;
        rom[3]  = 32'h8b050083;
        rom[4]  = 32'hf8018003;
        rom[63] = 32'hdeadbeef;
    end
    assign imem_q = rom[imem_addr];

    typedef struct {
        logic          rst, stl, fls, src;
        logic [N-1:0]  bt;
        logic [N-1:0]  e_pc;
        logic [N-1:0]  e_ifpc;
        logic [IW-1:0] e_instr;
        logic          e_valid;
    } vec_t;

    typedef struct {
        int            idx;
        logic [N-1:0]  pc;
        logic [N-1:0]  ifpc;
        logic [IW-1:0] instr;
        logic          valid;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    localparam logic [N-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    // Expected state after the clock edge at which each vector is applied
    vec_t vecs[] = '{
        '{1,0,0,0, 64'h0,    64'h0,   64'h0,   32'h0,        0}, // 0 reset
        '{0,0,0,0, 64'h0,    64'h4,   64'h0,   32'hf8000001, 1},
        '{0,0,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1},
        '{0,0,0,0, 64'h0,    64'hC,   64'h8,   32'hf8000203, 1},
        '{0,0,0,0, 64'h0,    64'h10,  64'hC,   32'h8b050083, 1},
        '{0,0,0,0, 64'h0,    64'h14,  64'h10,  32'hf8018003, 1},
        '{1,0,0,0, 64'h0,    64'h0,   64'h0,   32'h0,        0}, // 6 reset
        '{0,0,0,0, 64'h0,    64'h4,   64'h0,   32'hf8000001, 1},
        '{0,0,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1},
        '{0,1,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1}, // 9 stall
        '{0,1,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1},
        '{0,0,0,0, 64'h0,    64'hC,   64'h8,   32'hf8000203, 1},
        '{0,0,0,0, 64'h0,    64'h10,  64'hC,   32'h8b050083, 1},
        '{0,0,1,1, 64'h6,    64'h4,   64'h0,   32'h0,        0}, // 13 branch+flush
        '{0,0,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1},
        '{0,1,1,0, 64'h0,    64'h8,   64'h0,   32'h0,        0}, // 15 flush+stall
        '{0,0,0,0, 64'h0,    64'hC,   64'h8,   32'hf8000203, 1},
        '{1,0,0,0, 64'h0,    64'h0,   64'h0,   32'h0,        0}, // 17 reset mid-run
        '{0,0,0,0, 64'h0,    64'h4,   64'h0,   32'hf8000001, 1},
        '{0,1,0,1, 64'h13,   64'h10,  64'h0,   32'hf8000001, 1}, // 19 branch during stall
        '{0,0,0,0, 64'h0,    64'h14,  64'h10,  32'hf8018003, 1},
        '{0,0,0,1, 64'hFF,   64'hFC,  64'h14,  32'h0,        1}, // 21 branch, wrong path loads
        '{0,0,0,0, 64'h0,    64'h100, 64'hFC,  32'hdeadbeef, 1},
        '{0,0,0,0, 64'h0,    64'h104, 64'h100, 32'hf8000001, 1}, // 23 ROM alias
        '{0,0,0,1, TOP,      TOP,     64'h104, 32'hf8008002, 1},
        '{0,0,0,0, 64'h0,    64'h0,   TOP,     32'hdeadbeef, 1}, // 25 PC wrap
        '{0,0,0,0, 64'h0,    64'h4,   64'h0,   32'hf8000001, 1},
        '{1,0,0,0, 64'h0,    64'h0,   64'h0,   32'h0,        0}, // 27 counter run
        '{0,0,0,0, 64'h0,    64'h4,   64'h0,   32'hf8000001, 1},
        '{0,0,0,0, 64'h0,    64'h8,   64'h4,   32'hf8008002, 1},
        '{0,0,0,0, 64'h0,    64'hC,   64'h8,   32'hf8000203, 1},
        '{0,0,0,0, 64'h0,    64'h10,  64'hC,   32'h8b050083, 1},
        '{0,0,0,0, 64'h0,    64'h14,  64'h10,  32'hf8018003, 1},
        '{0,0,1,0, 64'h0,    64'h18,  64'h0,   32'h0,        0}
    };

    // Monitor: every cycle after an edge is an observable IF/ID output
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (pc_if !== e.pc) begin
                bad++;
                $display("FAIL pc_if v%0d got=%h exp=%h", e.idx, pc_if, e.pc);
            end
            total++;
            if (imem_addr !== e.pc[AW+1:2]) begin
                bad++;
                $display("FAIL imem_addr v%0d got=%h exp=%h", e.idx, imem_addr, e.pc[AW+1:2]);
            end
            total++;
            if (if_id_pc !== e.ifpc) begin
                bad++;
                $display("FAIL if_id_pc v%0d got=%h exp=%h", e.idx, if_id_pc, e.ifpc);
            end
            total++;
            if (if_id_instr !== e.instr) begin
                bad++;
                $display("FAIL if_id_instr v%0d got=%h exp=%h", e.idx, if_id_instr, e.instr);
            end
            total++;
            if (if_id_valid !== e.valid) begin
                bad++;
                $display("FAIL if_id_valid v%0d got=%b exp=%b", e.idx, if_id_valid, e.valid);
            end
        end
    end

    initial begin
        int budget;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            flush         = vecs[i].fls;
            pc_src        = vecs[i].src;
            branch_target = vecs[i].bt;
            e.idx   = i;
            e.pc    = vecs[i].e_pc;
            e.ifpc  = vecs[i].e_ifpc;
            e.instr = vecs[i].e_instr;
            e.valid = vecs[i].e_valid;
            exp_q.push_back(e);
        end
        @(negedge clk);
        reset = 1'b0; stall = 1'b1; flush = 1'b0; pc_src = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_count !== 32'd5) begin
            bad++;
            $display("FAIL fetch_count got=%0d exp=5", fetch_count);
        end
        total++;
        if (bubble_count !== 32'd1) begin
            bad++;
            $display("FAIL bubble_count got=%0d exp=1", bubble_count);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
